lift_scan_ctrl: RTL and testbench
=================================

Name: lift_scan_ctrl

Overview:
- Parametrised successor to the fixed 7-floor lift FSM: N floors, timed travel and timed door dwell.
- Hall and car requests are latched internally. A SCAN (elevator) policy keeps the car moving in one direction while requests lie ahead, then reverses.
- Sits between the button panels/indicators and the motor/door drivers.
- Per-floor acknowledge outputs clear the external button lamps.

Parameters:
- N_FLOORS, 7, number of floors; legal range 2..32. Floor 0 is the bottom floor.
- TRAVEL_CYCLES, 4, clock cycles to move one floor; must be >= 1.
- DOOR_CYCLES, 8, clock cycles the door stays open per stop; must be >= 1.
- FW, $clog2(N_FLOORS), width of the floor index (derived; not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- up_button  in  N_FLOORS  hall up requests, level or pulse; bit N_FLOORS-1 is ignored.
- down_button  in  N_FLOORS  hall down requests; bit 0 is ignored.
- inside_button  in  N_FLOORS  car requests.
- present_floor  out  N_FLOORS  one-hot current floor.
- floor_idx  out  FW  binary current floor.
- dir_up  out  1  current/last direction; 1 = up.
- moving  out  1  high in MOVE_UP and MOVE_DOWN.
- door_open  out  1  high in DOOR.
- reset_up  out  N_FLOORS  lamp clear, high while DOOR serves up at that floor.
- reset_down  out  N_FLOORS  lamp clear, high while DOOR serves down at that floor.
- reset_inside_button  out  N_FLOORS  lamp clear, high while DOOR is at that floor.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, floor_idx 0, present_floor 1, dir_up 1.
  - Counters 0; all pending registers clear; moving, door_open and all reset_* outputs 0.
- Request latching, every edge: pend_X <= (pend_X | X_button) & ~clr_X.
  - Clear wins over a new press at the floor being served, so presses during door-open are absorbed.
  - Illegal bits (up at top, down at bottom) are forced to 0.
- Derived terms, from registered pending and floor f:
  - ahead_up = any pending (any type) at floors > f.
  - ahead_dn = any pending at floors < f.
  - here_up = pend_up[f] | pend_in[f].
  - here_dn = pend_dn[f] | pend_in[f].
- IDLE:
  - If here_up or here_dn: go to DOOR. dir_up is set to 1 if pend_up[f], else 0 if pend_dn[f], else unchanged.
  - Else if ahead in current dir: MOVE that way.
  - Else if ahead in opposite dir: flip dir_up and MOVE.
  - Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Counter runs 0..TRAVEL_CYCLES-1. On terminal count, floor_idx changes by ±1.
  - The stop decision uses the arrival floor g in the same edge.
  - Stop at g if pend_in[g], or hall request in the travel direction at g, or (no requests beyond g in the travel direction and opposite hall request at g).
  - On a stop, enter DOOR on that edge; dir_up flips only in the last case.
  - Never move past floor 0 or N_FLOORS-1. At an end floor, a stop is forced.
- DOOR:
  - door_open = 1 for exactly DOOR_CYCLES cycles.
  - clr asserts every cycle for inside[f] and for the hall bit of f in direction dir_up; the corresponding reset_* outputs mirror clr.
  - On expiry:
    - If requests ahead in dir_up: MOVE same direction.
    - Else if opposite hall request at f: flip dir_up and restart DOOR, a full dwell.
    - Else if requests behind: flip and MOVE.
    - Otherwise go to IDLE.
- Simultaneous presses at the current floor while in IDLE are served in one dwell per direction: up first if dir_up = 1.
- Output timing: all outputs are registered or decoded from registered state; there is no combinational path from buttons to outputs.
- Reset mid-move or mid-door: immediate return to reset values, and all pending requests are lost.

Decomposition:
- Package lift_pkg holds:
  - state enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR}, 2 bits;
  - function any_above(vec, idx) / any_below(vec, idx);
  - function onehot(idx).
- One sub-module is natural: lift_req_latch, parametrised by N_FLOORS. It holds the three pending registers with set/clear-priority logic and illegal-bit masking.

Test Plan:
(N_FLOORS = 7, TRAVEL = 4, DOOR = 8 throughout.)
1. Reset, then inside_button[3] for 1 cycle at edge E0:
   - MOVE_UP at E1; floor_idx = 1, 2, 3 at E5, E9, E13, with DOOR entered at E13.
   - door_open and reset_inside_button[3] high for 8 cycles; then IDLE with floor_idx 3.
2. At floor 0, down_button[4] and up_button[2]:
   - Stop at 2 with reset_up[2] high.
   - Continue to 4; door at 4 with dir_up flipped to 0 and reset_down[4] high; then IDLE.
3. At floor 5 moving down toward a pending inside[1], press up_button[3]:
   - No stop at 3; door at 1.
   - Then reverse, door at 3 with reset_up[3].
4. In IDLE at floor 2, up_button[2] and down_button[2] together:
   - Two consecutive 8-cycle dwells: reset_up[2] first, then reset_down[2].
   - Total 16 door-open cycles, then IDLE.
5. Illegal bits:
   - up_button[6] and down_button[0] only: no pending latched; stays IDLE.
   - rst_n low mid-MOVE: floor_idx 0 and moving 0 immediately (asynchronous).
6. Hold inside_button[4] high through the door dwell at floor 4:
   - Door closes after exactly 8 cycles; no re-open while the button remains held.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and helpers for the SCAN lift controller.
// Floor vectors are handled at a fixed 32-bit width so helpers work for any legal floor count.
package lift_pkg;

   localparam int MAX_FLOORS = 32;
   localparam int IDX_W      = 5;

   typedef enum logic [1:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      DOOR
   } state_t;

   function automatic logic any_above(input logic [MAX_FLOORS-1:0] vec,
                                      input logic [IDX_W-1:0]      idx);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if (i > int'(idx)) hit = hit | vec[i];
      return hit;
   endfunction

   function automatic logic any_below(input logic [MAX_FLOORS-1:0] vec,
                                      input logic [IDX_W-1:0]      idx);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if (i < int'(idx)) hit = hit | vec[i];
      return hit;
   endfunction

   function automatic logic [MAX_FLOORS-1:0] onehot(input logic [IDX_W-1:0] idx);
      return {{(MAX_FLOORS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/lift_req_latch.sv
// Pending-request registers for hall up/down and car buttons.
// A clear at the served floor beats a simultaneous press; illegal hall bits never latch.
module lift_req_latch
   import lift_pkg::*;
#(
   parameter int N_FLOORS = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] up_button,
   input  logic [N_FLOORS-1:0] down_button,
   input  logic [N_FLOORS-1:0] inside_button,
   input  logic [N_FLOORS-1:0] clr_up,
   input  logic [N_FLOORS-1:0] clr_dn,
   input  logic [N_FLOORS-1:0] clr_in,
   output logic [N_FLOORS-1:0] pend_up,
   output logic [N_FLOORS-1:0] pend_dn,
   output logic [N_FLOORS-1:0] pend_in
);

   localparam logic [N_FLOORS-1:0] UP_LEGAL = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DN_LEGAL = {{(N_FLOORS-1){1'b1}}, 1'b0};

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; pending requests are reset so a reset drops all calls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_up <= '0;
         pend_dn <= '0;
         pend_in <= '0;
      end else begin
         pend_up <= (pend_up | up_button)     & ~clr_up & UP_LEGAL;
         pend_dn <= (pend_dn | down_button)   & ~clr_dn & DN_LEGAL;
         pend_in <= (pend_in | inside_button) & ~clr_in;
      end
   end

endmodule

// File: rtl/lift_scan_ctrl.sv
// SCAN lift controller: N floors, timed travel per floor and timed door dwell.
// Keeps moving while requests lie ahead, serves stops on arrival, then reverses.
module lift_scan_ctrl
   import lift_pkg::*;
#(
   parameter int  N_FLOORS      = 7,
   parameter int  TRAVEL_CYCLES = 4,
   parameter int  DOOR_CYCLES   = 8,
   localparam int FW            = $clog2(N_FLOORS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] up_button,
   input  logic [N_FLOORS-1:0] down_button,
   input  logic [N_FLOORS-1:0] inside_button,
   output logic [N_FLOORS-1:0] present_floor,
   output logic [FW-1:0]       floor_idx,
   output logic                dir_up,
   output logic                moving,
   output logic                door_open,
   output logic [N_FLOORS-1:0] reset_up,
   output logic [N_FLOORS-1:0] reset_down,
   output logic [N_FLOORS-1:0] reset_inside_button
);

   localparam int TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int DW = $clog2(DOOR_CYCLES + 1);
   localparam logic [TW-1:0]       TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0]       DOOR_LAST   = DW'(DOOR_CYCLES - 1);
   localparam logic [IDX_W-1:0]    TOP_IDX     = IDX_W'(N_FLOORS - 1);
   localparam logic [N_FLOORS-1:0] UP_LEGAL    = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DN_LEGAL    = {{(N_FLOORS-1){1'b1}}, 1'b0};

   state_t            state, state_d;
   logic [FW-1:0]     floor_d;
   logic              dir_d;
   logic [TW-1:0]     travel_cnt, travel_d;
   logic [DW-1:0]     door_cnt, door_d;
   logic [N_FLOORS-1:0] pend_up, pend_dn, pend_in;
   logic [N_FLOORS-1:0] clr_up, clr_dn, clr_in;
   logic [N_FLOORS-1:0] floor_hot;

   lift_req_latch #(.N_FLOORS(N_FLOORS)) u_req (
      .clk           (clk),
      .rst_n         (rst_n),
      .up_button     (up_button),
      .down_button   (down_button),
      .inside_button (inside_button),
      .clr_up        (clr_up),
      .clr_dn        (clr_dn),
      .clr_in        (clr_in),
      .pend_up       (pend_up),
      .pend_dn       (pend_dn),
      .pend_in       (pend_in)
   );

   // Request terms evaluated in a fixed-width domain so any index stays in range.
   logic [MAX_FLOORS-1:0] pu_w, pd_w, pi_w, pall_w;
   logic [IDX_W-1:0]      f_w, g_w;
   logic ahead_up, ahead_dn, here_up, here_dn;
   logic move_dn, beyond_g, same_g, opp_g, g_end;

   assign pu_w   = MAX_FLOORS'(pend_up);
   assign pd_w   = MAX_FLOORS'(pend_dn);
   assign pi_w   = MAX_FLOORS'(pend_in);
   assign pall_w = pu_w | pd_w | pi_w;
   assign f_w    = IDX_W'(floor_idx);

   assign ahead_up = any_above(pall_w, f_w);
   assign ahead_dn = any_below(pall_w, f_w);
   assign here_up  = pu_w[f_w] | pi_w[f_w];
   assign here_dn  = pd_w[f_w] | pi_w[f_w];

   assign move_dn  = (state == MOVE_DOWN);
   assign g_w      = move_dn ? f_w - IDX_W'(1) : f_w + IDX_W'(1);
   assign beyond_g = move_dn ? any_below(pall_w, g_w) : any_above(pall_w, g_w);
   assign same_g   = move_dn ? pd_w[g_w] : pu_w[g_w];
   assign opp_g    = move_dn ? pu_w[g_w] : pd_w[g_w];
   assign g_end    = move_dn ? (g_w == '0) : (g_w == TOP_IDX);

   assign floor_hot = N_FLOORS'(onehot(f_w));

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      state_d  = state;
      floor_d  = floor_idx;
      dir_d    = dir_up;
      travel_d = travel_cnt;
      door_d   = door_cnt;
      clr_up   = '0;
      clr_dn   = '0;
      clr_in   = '0;

      case (state)
         IDLE: begin
            if (here_up || here_dn) begin
               state_d = DOOR;
               if (pu_w[f_w])      dir_d = 1'b1;
               else if (pd_w[f_w]) dir_d = 1'b0;
            end else if (ahead_up && (dir_up || !ahead_dn)) begin
               state_d = MOVE_UP;
               dir_d   = 1'b1;
            end else if (ahead_dn) begin
               state_d = MOVE_DOWN;
               dir_d   = 1'b0;
            end
         end

         MOVE_UP, MOVE_DOWN: begin
            if (travel_cnt != TRAVEL_LAST) begin
               travel_d = travel_cnt + TW'(1);
            end else begin
               travel_d = '0;
               floor_d  = FW'(g_w);
               if (pi_w[g_w] || same_g) begin
                  state_d = DOOR;
               end else if (!beyond_g && opp_g) begin
                  state_d = DOOR;
                  dir_d   = ~dir_up;
               end else if (!beyond_g || g_end) begin
                  state_d = DOOR;
               end
            end
         end

         DOOR: begin
            clr_in = floor_hot;
            if (dir_up) clr_up = floor_hot & UP_LEGAL;
            else        clr_dn = floor_hot & DN_LEGAL;

            if (door_cnt != DOOR_LAST) begin
               door_d = door_cnt + DW'(1);
            end else begin
               door_d = '0;
               if (dir_up ? ahead_up : ahead_dn) begin
                  state_d = dir_up ? MOVE_UP : MOVE_DOWN;
               end else if (dir_up ? pd_w[f_w] : pu_w[f_w]) begin
                  // Opposite hall call here: stay in DOOR for a fresh dwell.
                  dir_d = ~dir_up;
               end else if (dir_up ? ahead_dn : ahead_up) begin
                  dir_d   = ~dir_up;
                  state_d = dir_up ? MOVE_DOWN : MOVE_UP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         floor_idx  <= '0;
         dir_up     <= 1'b1;
         travel_cnt <= '0;
         door_cnt   <= '0;
      end else begin
         state      <= state_d;
         floor_idx  <= floor_d;
         dir_up     <= dir_d;
         travel_cnt <= travel_d;
         door_cnt   <= door_d;
      end
   end

   assign present_floor       = floor_hot;
   assign moving              = (state == MOVE_UP) || (state == MOVE_DOWN);
   assign door_open           = (state == DOOR);
   assign reset_up            = clr_up;
   assign reset_down          = clr_dn;
   assign reset_inside_button = clr_in;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Directed bench for lift_scan_ctrl (7 floors, travel 4, dwell 8).
// Table vectors cover the main trips; hand sequences cover async reset and a held button.
module tb_lift_scan_ctrl;

   localparam int N = 7;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] up_button = '0;
   logic [N-1:0] down_button = '0;
   logic [N-1:0] inside_button = '0;
   logic [N-1:0] present_floor;
   logic [2:0]   floor_idx;
   logic         dir_up, moving, door_open;
   logic [N-1:0] reset_up, reset_down, reset_inside_button;

   lift_scan_ctrl #(
      .N_FLOORS      (N),
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (8)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .up_button           (up_button),
      .down_button         (down_button),
      .inside_button       (inside_button),
      .present_floor       (present_floor),
      .floor_idx           (floor_idx),
      .dir_up              (dir_up),
      .moving              (moving),
      .door_open           (door_open),
      .reset_up            (reset_up),
      .reset_down          (reset_down),
      .reset_inside_button (reset_inside_button)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string        name;
      bit           rst;
      logic [N-1:0] up, dn, in;
      int           wait_cyc;
      int           floor;
      bit           moving, door, dir;
      logic [N-1:0] rup, rdn, rin;
   } vec_t;

   vec_t vecs[$];
   localparam logic [N-1:0] Z = '0;

   function automatic logic [N-1:0] b(input int n);
      return N'(1) << n;
   endfunction

   function automatic void add(input string name, input bit rst,
                               input logic [N-1:0] up, input logic [N-1:0] dn,
                               input logic [N-1:0] in, input int wait_cyc,
                               input int floor, input bit mv, input bit door,
                               input bit dir, input logic [N-1:0] rup,
                               input logic [N-1:0] rdn, input logic [N-1:0] rin);
      vec_t v;
      v.name = name; v.rst = rst; v.up = up; v.dn = dn; v.in = in;
      v.wait_cyc = wait_cyc; v.floor = floor; v.moving = mv; v.door = door;
      v.dir = dir; v.rup = rup; v.rdn = rdn; v.rin = rin;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input int fl, input bit mv,
                                input bit door, input bit dir, input logic [N-1:0] rup,
                                input logic [N-1:0] rdn, input logic [N-1:0] rin);
      check({tag, ".floor_idx"},     32'(floor_idx),           32'(fl));
      check({tag, ".present_floor"}, 32'(present_floor),       32'(1) << fl);
      check({tag, ".moving"},        32'(moving),              32'(mv));
      check({tag, ".door_open"},     32'(door_open),           32'(door));
      check({tag, ".dir_up"},        32'(dir_up),              32'(dir));
      check({tag, ".reset_up"},      32'(reset_up),            32'(rup));
      check({tag, ".reset_down"},    32'(reset_down),          32'(rdn));
      check({tag, ".reset_inside"},  32'(reset_inside_button), 32'(rin));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      up_button = '0; down_button = '0; inside_button = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_outputs("reset", 0, 1'b0, 1'b0, 1'b1, Z, Z, Z);
   endtask

   task automatic run_vec(input vec_t v);
      if (v.rst) do_reset();
      up_button = v.up; down_button = v.dn; inside_button = v.in;
      for (int c = 0; c < v.wait_cyc; c++) begin
         @(posedge clk);
         #1;
         up_button = '0; down_button = '0; inside_button = '0;
      end
      check_outputs(v.name, v.floor, v.moving, v.door, v.dir, v.rup, v.rdn, v.rin);
   endtask

   initial begin
      int found, door_cycles, reopen;

      // name, rst, up, dn, in, wait, floor, moving, door, dir, rup, rdn, rin
      add("t1_e0",   1, Z, Z, b(3), 1, 0, 0, 0, 1, Z, Z, Z);
      add("t1_e1",   0, Z, Z, Z,    1, 0, 1, 0, 1, Z, Z, Z);
      add("t1_e5",   0, Z, Z, Z,    4, 1, 1, 0, 1, Z, Z, Z);
      add("t1_e8",   0, Z, Z, Z,    3, 1, 1, 0, 1, Z, Z, Z);
      add("t1_e9",   0, Z, Z, Z,    1, 2, 1, 0, 1, Z, Z, Z);
      add("t1_e13",  0, Z, Z, Z,    4, 3, 0, 1, 1, b(3), Z, b(3));
      add("t1_e20",  0, Z, Z, Z,    7, 3, 0, 1, 1, b(3), Z, b(3));
      add("t1_e21",  0, Z, Z, Z,    1, 3, 0, 0, 1, Z, Z, Z);

      add("t2_e0",   1, b(2), b(4), Z, 1, 0, 0, 0, 1, Z, Z, Z);
      add("t2_e1",   0, Z, Z, Z,    1, 0, 1, 0, 1, Z, Z, Z);
      add("t2_e9",   0, Z, Z, Z,    8, 2, 0, 1, 1, b(2), Z, b(2));
      add("t2_e16",  0, Z, Z, Z,    7, 2, 0, 1, 1, b(2), Z, b(2));
      add("t2_e17",  0, Z, Z, Z,    1, 2, 1, 0, 1, Z, Z, Z);
      add("t2_e25",  0, Z, Z, Z,    8, 4, 0, 1, 0, Z, b(4), b(4));
      add("t2_e33",  0, Z, Z, Z,    8, 4, 0, 0, 0, Z, Z, Z);

      add("t3_go5",  0, Z, Z, b(5), 1, 4, 0, 0, 0, Z, Z, Z);
      add("t3_mv5",  0, Z, Z, Z,    1, 4, 1, 0, 1, Z, Z, Z);
      add("t3_at5",  0, Z, Z, Z,    4, 5, 0, 1, 1, b(5), Z, b(5));
      add("t3_idle5",0, Z, Z, Z,    8, 5, 0, 0, 1, Z, Z, Z);
      add("t3_call1",0, Z, Z, b(1), 1, 5, 0, 0, 1, Z, Z, Z);
      add("t3_mvdn", 0, Z, Z, Z,    1, 5, 1, 0, 0, Z, Z, Z);
      add("t3_hall3",0, b(3), Z, Z, 1, 5, 1, 0, 0, Z, Z, Z);
      add("t3_pass3",0, Z, Z, Z,    7, 3, 1, 0, 0, Z, Z, Z);
      add("t3_at1",  0, Z, Z, Z,    8, 1, 0, 1, 0, Z, b(1), b(1));
      add("t3_rev",  0, Z, Z, Z,    8, 1, 1, 0, 1, Z, Z, Z);
      add("t3_at3",  0, Z, Z, Z,    8, 3, 0, 1, 1, b(3), Z, b(3));
      add("t3_idle3",0, Z, Z, Z,    8, 3, 0, 0, 1, Z, Z, Z);

      add("t4_go2",  1, Z, Z, b(2), 1, 0, 0, 0, 1, Z, Z, Z);
      add("t4_mv",   0, Z, Z, Z,    1, 0, 1, 0, 1, Z, Z, Z);
      add("t4_at2",  0, Z, Z, Z,    8, 2, 0, 1, 1, b(2), Z, b(2));
      add("t4_idle2",0, Z, Z, Z,    8, 2, 0, 0, 1, Z, Z, Z);
      add("t4_both", 0, b(2), b(2), Z, 1, 2, 0, 0, 1, Z, Z, Z);
      add("t4_up_s", 0, Z, Z, Z,    1, 2, 0, 1, 1, b(2), Z, b(2));
      add("t4_up_e", 0, Z, Z, Z,    7, 2, 0, 1, 1, b(2), Z, b(2));
      add("t4_dn_s", 0, Z, Z, Z,    1, 2, 0, 1, 0, Z, b(2), b(2));
      add("t4_dn_e", 0, Z, Z, Z,    7, 2, 0, 1, 0, Z, b(2), b(2));
      add("t4_idle", 0, Z, Z, Z,    1, 2, 0, 0, 0, Z, Z, Z);

      add("t5_illegal", 1, b(6), b(0), Z, 1, 0, 0, 0, 1, Z, Z, Z);
      add("t5_quiet",   0, Z, Z, Z,       6, 0, 0, 0, 1, Z, Z, Z);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Asynchronous reset in the middle of a trip drops position and requests.
      do_reset();
      inside_button = b(6);
      @(posedge clk);
      #1 inside_button = '0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check("t5_premove.floor_idx", 32'(floor_idx), 32'd2);
      check("t5_premove.moving",    32'(moving),    32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("t5_async.floor_idx",     32'(floor_idx),     32'd0);
      check("t5_async.moving",        32'(moving),        32'd0);
      check("t5_async.present_floor", 32'(present_floor), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check("t5_lost.moving",    32'(moving),    32'd0);
      check("t5_lost.door_open", 32'(door_open), 32'd0);
      check("t5_lost.floor_idx", 32'(floor_idx), 32'd0);

      // Car button held through the dwell at its own floor.
      do_reset();
      inside_button = b(4);
      found = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (door_open) begin
            found = 1;
            break;
         end
      end
      check("t6_door_reached", 32'(found),     32'd1);
      check("t6_floor",        32'(floor_idx), 32'd4);
      door_cycles = 1;
      repeat (7) begin
         @(posedge clk);
         #1;
         if (door_open) door_cycles++;
      end
      inside_button = '0;
      @(posedge clk);
      #1;
      check("t6_dwell",  32'(door_cycles), 32'd8);
      check("t6_closed", 32'(door_open),   32'd0);
      reopen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (door_open || moving) reopen++;
      end
      check("t6_no_reopen", 32'(reopen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
